rr_hold_arbiter: RTL and testbench

Round-robin arbiter with grant holding, sharing a single resource among N requesters. Each requester keeps its grant while its request stays asserted, but only for a bounded number of cycles. Under contention it is forced to rotate after MAX_HOLD cycles. It is the fair companion to the fixed-priority arbiter and presents the same req/gnt one-hot contract to the shared datapath.

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/rr_hold_arbiter_sva.sv | 49 ++++
 rtl/rr_pick.sv | 25 ++
 rtl/rr_hold_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Imported by the picker, the arbiter top and its checker.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int unsigned onehot_to_idx(
    input logic [31:0] oh
  );
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_hold_arbiter_sva.sv
// Protocol checker bound into rr_hold_arbiter: one-hot grant, valid
// consistency, no grant without request, bounded hold under contention.
module rr_hold_arbiter_sva #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic [N-1:0] req,
  input logic [N-1:0] gnt,
  input logic         gnt_valid
);

  int           run_q, run_d;
  logic [N-1:0] prev_q;

  // Cycles the current grant has been visible, including this one
  always_comb begin
    run_d = 0;
    if (gnt != '0) begin
      if (gnt != prev_q)         run_d = 1;
      else if (run_q < MAX_HOLD) run_d = run_q + 1;
      else                       run_d = run_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 0;
      prev_q <= '0;
    end else begin
      run_q  <= run_d;
      prev_q <= gnt;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_valid: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid == (|gnt));

  a_req: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt & ~$past(req)) == '0);

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (run_d >= MAX_HOLD && (req & ~gnt) != '0) |=> gnt != $past(gnt));

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit at or above ptr,
// wrapping to bit 0, via a double-width rotate and lowest-bit mask.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N   = 3,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  always_comb begin
    rot    = N'({req, req} >> ptr);
    rot_oh = rot & (~rot + N'(1));
    gnt    = N'(({rot_oh, rot_oh} << ptr) >> N);
    idx    = IDW'(onehot_to_idx(32'(gnt)));
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter where the owner keeps the grant while it requests,
// but is rotated out after MAX_HOLD cycles if anyone else is waiting.
module rr_hold_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N        = 3,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;

  logic           rel, pre;
  logic [IDW-1:0] owner_nxt;
  logic [N-1:0]   others;
  logic [N-1:0]   pick_req, pick_gnt;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;

  // Candidate select: release scans all requests, preempt excludes owner
  always_comb begin
    owner_nxt = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
    others    = req & ~(N'(1) << owner_q);
    rel       = (state_q == GRANT) && !req[owner_q];
    pre       = (state_q == GRANT) && !rel &&
                (hold_q == HOLD_LAST) && (|others);
    ptr_d     = (rel || pre) ? owner_nxt : ptr_q;
    pick_req  = pre ? others : req;
  end

  rr_pick #(.N(N)) u_pick (
    .req (pick_req),
    .ptr (ptr_d),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign pick_any = |pick_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        unique case (1'b1)
          rel: begin
            if (pick_any) begin
              owner_d = pick_idx;
              hold_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
          pre: begin
            owner_d = pick_idx;
            hold_d  = '0;
          end
          default: begin
            if (hold_q != HOLD_LAST) hold_d = hold_q + HW'(1);
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    gnt_id_d    = '0;
    gnt_valid_d = 1'b0;
    if (state_d == GRANT) begin
      gnt_d       = N'(1) << owner_d;
      gnt_id_d    = owner_d;
      gnt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed plus random bench for rr_hold_arbiter, checked against an
// integer-level round-robin model (MAX_HOLD=4 and MAX_HOLD=1 instances).
module tb_rr_hold_arbiter;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_a, req_b;
  logic [N-1:0] gnt_a, gnt_b;
  logic         gv_a, gv_b;
  logic [1:0]   id_a, id_b;

  int n_assert;
  int n_fail;
  int m_own[2];
  int m_ptr[2];
  int m_run[2];
  int mh[2];

  always #5 clk = ~clk;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_a),
    .gnt       (gnt_a),
    .gnt_valid (gv_a),
    .gnt_id    (id_a)
  );

  rr_hold_arbiter #(.N(N), .MAX_HOLD(1)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_b),
    .gnt       (gnt_b),
    .gnt_valid (gv_b),
    .gnt_id    (id_b)
  );

  function automatic int pick(input logic [N-1:0] c, input int p);
    for (int j = 0; j < N; j++) begin
      if (c[(p + j) % N]) return (p + j) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1;
      m_ptr[k] = 0;
      m_run[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [N-1:0] r);
    int o;
    logic [N-1:0] oth;
    o = m_own[k];
    if (o < 0) begin
      o = pick(r, m_ptr[k]);
      m_run[k] = (o >= 0) ? 1 : 0;
    end else if (!r[o]) begin
      m_ptr[k] = (o + 1) % N;
      o = pick(r, m_ptr[k]);
      m_run[k] = (o >= 0) ? 1 : 0;
    end else begin
      oth = r;
      oth[o] = 1'b0;
      if (m_run[k] >= mh[k] && oth != '0) begin
        m_ptr[k] = (o + 1) % N;
        o = pick(oth, m_ptr[k]);
        m_run[k] = 1;
      end else begin
        m_run[k]++;
      end
    end
    m_own[k] = o;
  endtask

  task automatic chk(input string tag, input int k, input logic [N-1:0] g,
                     input logic [1:0] id, input logic v);
    logic [N-1:0] eg;
    logic [1:0]   eid;
    logic         ev;
    eg  = '0;
    eid = '0;
    ev  = 1'b0;
    if (m_own[k] >= 0) begin
      eg[m_own[k]] = 1'b1;
      eid = 2'(m_own[k]);
      ev  = 1'b1;
    end
    n_assert++;
    assert (g === eg) else begin
      n_fail++;
      $error("FAIL %s.gnt observed=%b expected=%b", tag, g, eg);
    end
    n_assert++;
    assert (id === eid) else begin
      n_fail++;
      $error("FAIL %s.gnt_id observed=%0d expected=%0d", tag, id, eid);
    end
    n_assert++;
    assert (v === ev) else begin
      n_fail++;
      $error("FAIL %s.gnt_valid observed=%b expected=%b", tag, v, ev);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a"}, 0, gnt_a, id_a, gv_a);
    chk({tag, "_b"}, 1, gnt_b, id_b, gv_b);
  endtask

  task automatic lit(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] ra, input logic [N-1:0] rb,
                     input string tag);
    req_a = ra;
    req_b = rb;
    model_step(0, ra);
    model_step(1, rb);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    lit({tag, "_gnt"}, int'(gnt_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mh[0]    = 4;
    mh[1]    = 1;
    req_a    = '0;
    req_b    = '0;
    rst_n    = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(3'b001, 3'b101, "single");
      lit("single_gnt", int'(gnt_a), 1);
      lit("mh1_alt", int'(gnt_b), (i % 2 == 0) ? 1 : 4);
    end
    cyc(3'b000, 3'b000, "drop");
    lit("drop_gnt", int'(gnt_a), 0);

    do_reset("rst_cont");
    for (int i = 0; i < 13; i++) begin
      cyc(3'b111, 3'b111, "cont");
      lit("cont_id", int'(id_a), (i / 4) % 3);
      lit("cont_oh", int'($onehot(gnt_a)), 1);
    end

    do_reset("rst_bubble");
    cyc(3'b011, 3'b011, "bubble");
    cyc(3'b011, 3'b011, "bubble");
    lit("bubble_hold", int'(gnt_a), 1);
    cyc(3'b010, 3'b010, "bubble");
    lit("bubble_gnt", int'(gnt_a), 2);
    lit("bubble_valid", int'(gv_a), 1);

    cyc(3'b000, 3'b000, "fair_rel");
    cyc(3'b111, 3'b111, "fair");
    lit("fair_gnt", int'(gnt_a), 4);

    do_reset("rst_pre");
    cyc(3'b010, 3'b010, "mid");
    lit("mid_gnt", int'(gnt_a), 2);
    do_reset("async");
    cyc(3'b110, 3'b110, "after_rst");
    lit("after_rst_gnt", int'(gnt_a), 2);

    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset("rand_rst");
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

bind rr_hold_arbiter rr_hold_arbiter_sva #(
  .N        (N),
  .MAX_HOLD (MAX_HOLD)
) u_sva (
  .clk       (clk),
  .rst_n     (rst_n),
  .req       (req),
  .gnt       (gnt),
  .gnt_valid (gnt_valid)
);
